// File: rtl/pipe_pkg.sv
// Shared types for the integer pipeline interlock: scoreboard slot record,
// controller state encoding and register-file constants.
package pipe_pkg;

  localparam int unsigned AW = 4;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rt;
    logic          writes;
    logic          jmp;
  } slot_t;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StBrWait = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } state_e;

  // True when a slot will commit a write that a later reader must wait for.
  function automatic logic slot_pending_write(slot_t s);
    return s.valid & s.writes;
  endfunction

endpackage

// File: rtl/raw_hazard_cmp.sv
// Compares one decode source register against every in-flight slot and flags
// a read-after-write hit. Register 0 reads as zero and never hits.
module raw_hazard_cmp
  import pipe_pkg::*;
#(
  parameter int unsigned NSLOT = 3
) (
  input  logic                i_use,
  input  logic [AW-1:0]       i_src,
  input  slot_t [NSLOT-1:0]   i_slots,
  output logic                o_hit
);

  always_comb begin
    o_hit = 1'b0;
    if (i_use && (i_src != REG_ZERO)) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (slot_pending_write(i_slots[i]) && (i_slots[i].rt == i_src)) begin
          o_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// Decode-side issue/interlock controller: scoreboards M/E/W writes, stalls on
// RAW hazards, serialises conditional jumps and sequences pipeline halt.
module pipeline_interlock_ctrl #(
  parameter int unsigned NSLOT = 3,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [AW-1:0]     d_ra,
  input  logic [AW-1:0]     d_r2,
  input  logic              d_use_ra,
  input  logic              d_use_r2,
  input  logic [AW-1:0]     d_rt,
  input  logic              d_writes,
  input  logic              d_is_jmp,
  input  logic              d_is_invalid,
  input  logic              flush,
  output logic              issue,
  output logic              stall,
  output logic [(2**AW)-1:0] busy_mask,
  output logic              halted,
  output logic [1:0]        state
);

  import pipe_pkg::*;

  state_e             r_state;
  state_e             w_state_nxt;
  slot_t [NSLOT-1:0]  r_slot;
  slot_t [NSLOT-1:0]  w_slot_nxt;
  logic               w_hit_ra;
  logic               w_hit_r2;
  logic               w_hazard;
  logic               w_any_valid;

  raw_hazard_cmp #(
    .NSLOT (NSLOT)
  ) u_cmp_ra (
    .i_use   (d_use_ra),
    .i_src   (d_ra),
    .i_slots (r_slot),
    .o_hit   (w_hit_ra)
  );

  raw_hazard_cmp #(
    .NSLOT (NSLOT)
  ) u_cmp_r2 (
    .i_use   (d_use_r2),
    .i_src   (d_r2),
    .i_slots (r_slot),
    .o_hit   (w_hit_r2)
  );

  assign w_hazard = w_hit_ra | w_hit_r2;

  always_comb begin
    w_any_valid = 1'b0;
    busy_mask   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      w_any_valid = w_any_valid | r_slot[i].valid;
      if (slot_pending_write(r_slot[i])) begin
        busy_mask[r_slot[i].rt] = 1'b1;
      end
    end
    // Console writes to r0 are not tracked.
    busy_mask[0] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    issue       = 1'b0;
    halted      = 1'b0;
    unique case (r_state)
      StRun: begin
        issue = d_valid & ~w_hazard & ~flush;
        if (issue && d_is_invalid) begin
          w_state_nxt = StDrain;
        end else if (issue && d_is_jmp) begin
          w_state_nxt = StBrWait;
        end
      end
      StBrWait: begin
        // Jump has reached E; it resolves this cycle, so reopen issue next.
        if (r_slot[1].valid && r_slot[1].jmp) begin
          w_state_nxt = StRun;
        end
      end
      StDrain: begin
        if (!w_any_valid) begin
          w_state_nxt = StHalted;
        end
      end
      StHalted: begin
        halted = 1'b1;
      end
    endcase
    if (flush && ((r_state == StRun) || (r_state == StBrWait))) begin
      w_state_nxt = StRun;
    end
  end

  assign stall = (d_valid & ~issue & ~flush) | halted;
  assign state = r_state;

  always_comb begin
    w_slot_nxt = '0;
    if (issue) begin
      w_slot_nxt[0].valid  = 1'b1;
      w_slot_nxt[0].rt     = d_rt;
      w_slot_nxt[0].writes = d_writes;
      w_slot_nxt[0].jmp    = d_is_jmp;
    end
    for (int i = 1; i < NSLOT; i++) begin
      w_slot_nxt[i] = r_slot[i-1];
    end
    // A taken jump in E kills the younger instruction sitting in M.
    if (flush) begin
      w_slot_nxt[1].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Directed self-checking bench for pipeline_interlock_ctrl: RAW stalls, r0
// writes, jump serialisation, flush priority, halt sequencing and reset.
module tb_pipeline_interlock_ctrl;

  localparam logic [1:0] SRUN = 2'd0;
  localparam logic [1:0] SBRW = 2'd1;
  localparam logic [1:0] SDRN = 2'd2;
  localparam logic [1:0] SHLT = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid;
  logic [3:0]  d_ra;
  logic [3:0]  d_r2;
  logic        d_use_ra;
  logic        d_use_r2;
  logic [3:0]  d_rt;
  logic        d_writes;
  logic        d_is_jmp;
  logic        d_is_invalid;
  logic        flush;
  logic        issue;
  logic        stall;
  logic [15:0] busy_mask;
  logic        halted;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_interlock_ctrl #(
    .NSLOT (3),
    .AW    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_valid      (d_valid),
    .d_ra         (d_ra),
    .d_r2         (d_r2),
    .d_use_ra     (d_use_ra),
    .d_use_r2     (d_use_r2),
    .d_rt         (d_rt),
    .d_writes     (d_writes),
    .d_is_jmp     (d_is_jmp),
    .d_is_invalid (d_is_invalid),
    .flush        (flush),
    .issue        (issue),
    .stall        (stall),
    .busy_mask    (busy_mask),
    .halted       (halted),
    .state        (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic ei, input logic es, input logic [15:0] eb,
                     input logic [1:0] est, input logic eh);
    chk({tag, ".issue"}, {31'd0, issue}, {31'd0, ei});
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, es});
    chk({tag, ".busy"}, {16'd0, busy_mask}, {16'd0, eb});
    chk({tag, ".state"}, {30'd0, state}, {30'd0, est});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid      = 1'b0;
    d_ra         = 4'd0;
    d_r2         = 4'd0;
    d_use_ra     = 1'b0;
    d_use_r2     = 1'b0;
    d_rt         = 4'd0;
    d_writes     = 1'b0;
    d_is_jmp     = 1'b0;
    d_is_invalid = 1'b0;
  endtask

  task automatic instr(input logic [3:0] rt, input logic [3:0] ra, input logic [3:0] r2,
                       input logic use_ra, input logic use_r2, input logic wr,
                       input logic jmp, input logic inv);
    d_valid      = 1'b1;
    d_rt         = rt;
    d_ra         = ra;
    d_r2         = r2;
    d_use_ra     = use_ra;
    d_use_r2     = use_r2;
    d_writes     = wr;
    d_is_jmp     = jmp;
    d_is_invalid = inv;
  endtask

  // Idle long enough for every slot to leave W.
  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  initial begin
    idle();
    flush = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    ctl("reset", 1'b0, 1'b0, 16'h0000, SRUN, 1'b0);
    #8 rst_n = 1'b1;
    cyc();

    // RAW: sub r3=r1-r2 then sub r4=r3-r5 -> 3 stall cycles.
    instr(4'd3, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("raw.prod", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    instr(4'd4, 4'd3, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 3; k++) begin
      ctl($sformatf("raw.stall%0d", k), 1'b0, 1'b1, 16'h0008, SRUN, 1'b0);
      cyc();
    end
    ctl("raw.go", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    idle();
    #1 ctl("raw.after", 1'b0, 1'b0, 16'h0010, SRUN, 1'b0);
    drain();
    ctl("raw.empty", 1'b0, 1'b0, 16'h0000, SRUN, 1'b0);

    // r0 write never makes a reader wait.
    instr(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 ctl("r0.movl", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    instr(4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 ctl("r0.reader", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    idle();
    #1 ctl("r0.after", 1'b0, 1'b0, 16'h0020, SRUN, 1'b0);
    drain();

    // Independent stream issues back-to-back.
    instr(4'd1, 4'd8, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("ind.r1", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    instr(4'd2, 4'd10, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("ind.r2", 1'b1, 1'b0, 16'h0002, SRUN, 1'b0);
    cyc();
    instr(4'd6, 4'd12, 4'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("ind.r6", 1'b1, 1'b0, 16'h0006, SRUN, 1'b0);
    cyc();
    idle();
    #1 ctl("ind.mask", 1'b0, 1'b0, 16'h0046, SRUN, 1'b0);
    drain();

    // Jump resolved with flush=1.
    instr(4'd9, 4'd10, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("jf.r9", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    instr(4'd0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 ctl("jf.t", 1'b1, 1'b0, 16'h0200, SRUN, 1'b0);
    cyc();
    instr(4'd7, 4'd8, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 ctl("jf.t1", 1'b0, 1'b1, 16'h0200, SBRW, 1'b0);
    cyc();
    flush = 1'b1;
    #1 ctl("jf.t2", 1'b0, 1'b0, 16'h0200, SBRW, 1'b0);
    cyc();
    flush = 1'b0;
    #1 ctl("jf.t3", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    idle();
    #1 ctl("jf.t4", 1'b0, 1'b0, 16'h0080, SRUN, 1'b0);
    drain();

    // Jump resolved with flush=0.
    instr(4'd0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 ctl("jn.t", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    instr(4'd7, 4'd8, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 ctl("jn.t1", 1'b0, 1'b1, 16'h0000, SBRW, 1'b0);
    cyc();
    #1 ctl("jn.t2", 1'b0, 1'b1, 16'h0000, SBRW, 1'b0);
    cyc();
    ctl("jn.t3", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    idle();
    #1 ctl("jn.t4", 1'b0, 1'b0, 16'h0080, SRUN, 1'b0);
    drain();

    // Flush during a RAW stall: flush wins, M slot is killed, E moves to W.
    instr(4'd3, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("fh.r3", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    instr(4'd6, 4'd12, 4'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("fh.r6", 1'b1, 1'b0, 16'h0008, SRUN, 1'b0);
    cyc();
    instr(4'd4, 4'd3, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("fh.noflush", 1'b0, 1'b1, 16'h0048, SRUN, 1'b0);
    flush = 1'b1;
    #1 ctl("fh.flush", 1'b0, 1'b0, 16'h0048, SRUN, 1'b0);
    cyc();
    flush = 1'b0;
    idle();
    #1 ctl("fh.after", 1'b0, 1'b0, 16'h0008, SRUN, 1'b0);
    cyc();
    ctl("fh.gone", 1'b0, 1'b0, 16'h0000, SRUN, 1'b0);
    drain();

    // Invalid opcode -> DRAIN until empty -> HALTED.
    instr(4'd1, 4'd8, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("hl.a", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    instr(4'd2, 4'd10, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 ctl("hl.b", 1'b1, 1'b0, 16'h0002, SRUN, 1'b0);
    cyc();
    instr(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 ctl("hl.inv", 1'b1, 1'b0, 16'h0006, SRUN, 1'b0);
    cyc();
    idle();
    #1 ctl("hl.d0", 1'b0, 1'b0, 16'h0006, SDRN, 1'b0);
    cyc();
    ctl("hl.d1", 1'b0, 1'b0, 16'h0004, SDRN, 1'b0);
    cyc();
    ctl("hl.d2", 1'b0, 1'b0, 16'h0000, SDRN, 1'b0);
    cyc();
    ctl("hl.d3", 1'b0, 1'b0, 16'h0000, SDRN, 1'b0);
    cyc();
    ctl("hl.halt", 1'b0, 1'b1, 16'h0000, SHLT, 1'b1);
    instr(4'd5, 4'd6, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc();
      ctl($sformatf("hl.sticky%0d", k), 1'b0, 1'b1, 16'h0000, SHLT, 1'b1);
    end

    // Asynchronous reset out of HALTED.
    idle();
    #1 rst_n = 1'b0;
    #1 ctl("rst.halt", 1'b0, 1'b0, 16'h0000, SRUN, 1'b0);
    #2 rst_n = 1'b1;
    cyc();

    // Asynchronous reset with a live scoreboard entry.
    instr(4'd5, 4'd6, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 ctl("rst.issue", 1'b1, 1'b0, 16'h0000, SRUN, 1'b0);
    cyc();
    idle();
    #1 ctl("rst.busy", 1'b0, 1'b0, 16'h0020, SRUN, 1'b0);
    rst_n = 1'b0;
    #1 ctl("rst.clear", 1'b0, 1'b0, 16'h0000, SRUN, 1'b0);
    #2 rst_n = 1'b1;
    cyc();
    ctl("rst.post", 1'b0, 1'b0, 16'h0000, SRUN, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
